alsu_result_monitor: RTL

Downstream consumer of the ALSU registered outputs (6-bit signed result bus and 16-bit LED bus). Buffers qualified results in a small FIFO drained through a valid/ready port. Maintains running statistics: saturating sum, min, max and sample/drop counters. Detects the ALSU invalid-operation LED blink pattern and raises an alarm after a configurable run length.

---
 rtl/alsu_result_monitor.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alsu_result_monitor.sv
// ALSU result monitor: buffers qualified ALSU results in a small FIFO drained
// through a valid/ready port, keeps running statistics (saturating sum,
// min/max, sample and drop counters) and flags the ALSU invalid-operation
// LED blink pattern once it has persisted for BLINK_LIMIT cycles.
module alsu_result_monitor #(
    parameter int DEPTH       = 8,
    parameter int ACC_W       = 12,
    parameter int BLINK_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [5:0]               in_data,
    input  logic [15:0]              leds_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [ACC_W-1:0]         acc,
    output logic                     acc_sat,
    output logic [5:0]               min_val,
    output logic [5:0]               max_val,
    output logic [7:0]               sample_cnt,
    output logic [7:0]               drop_cnt,
    output logic                     blink_alarm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]           DEPTH_C  = CW'(DEPTH);
    localparam logic [4:0]              LIMIT_C  = 5'(BLINK_LIMIT);
    localparam logic signed [5:0]       SMP_MAX  = 6'sb011111;
    localparam logic signed [5:0]       SMP_MIN  = 6'sb100000;
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed view of the incoming ALSU result.
    logic signed [5:0] sample;
    assign sample = in_data;

    // Adds a sign-extended sample to the accumulator one bit wider than the
    // accumulator, then clamps. Returns {clamped_flag, clamped_sum}.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [5:0]       d
    );
        logic [ACC_W:0] s;
        logic [ACC_W:0] r;
        s = {a[ACC_W-1], a} + {{(ACC_W-5){d[5]}}, d};
        if (s[ACC_W] != s[ACC_W-1]) begin
            // The two top bits disagree: the true sum left the ACC_W range.
            r = {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        end else begin
            r = {1'b0, s[ACC_W-1:0]};
        end
        return r;
    endfunction

    // Increments an 8-bit counter, holding at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // FIFO state; storage is not reset, occupancy and pointers are.
    logic signed [5:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    // Statistics and blink state.
    logic signed [ACC_W-1:0] acc_q;
    logic                    acc_sat_q;
    logic signed [5:0]       min_q;
    logic signed [5:0]       max_q;
    logic [7:0]              sample_q;
    logic [7:0]              drop_q;
    logic [15:0]             leds_prev;
    logic [4:0]              blink_run;
    logic                    alarm_q;

    // Combinational decode.
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    blink_event;
    logic [4:0]              run_next;
    logic [ACC_W:0]          acc_add;
    logic signed [ACC_W-1:0] acc_next;
    logic                    acc_clamp;

    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign fifo_count  = count;
    assign acc         = acc_q;
    assign acc_sat     = acc_sat_q;
    assign min_val     = min_q;
    assign max_val     = max_q;
    assign sample_cnt  = sample_q;
    assign drop_cnt    = drop_q;
    assign blink_alarm = alarm_q;

    // Handshake decode, saturating sum and next blink run length.
    always_comb begin
        pop         = 1'b0;
        push        = 1'b0;
        drop        = 1'b0;
        blink_event = 1'b0;
        run_next    = '0;
        acc_add     = '0;
        acc_next    = acc_q;
        acc_clamp   = 1'b0;

        pop  = out_valid && out_ready;
        // A same-cycle pop frees a slot, so a full FIFO can still accept.
        push = in_valid && ((count < DEPTH_C) || pop);
        drop = in_valid && !push;

        acc_add   = sat_add(acc_q, sample);
        acc_next  = acc_add[ACC_W-1:0];
        acc_clamp = acc_add[ACC_W];

        blink_event = (leds_in == ~leds_prev);
        if (blink_event) begin
            run_next = (blink_run == LIMIT_C) ? LIMIT_C : blink_run + 5'd1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    // FIFO pointers and occupancy; rst discards all queued entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Running statistics; clr wins over a same-cycle sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            min_q     <= SMP_MAX;
            max_q     <= SMP_MIN;
            sample_q  <= '0;
            drop_q    <= '0;
        end else if (clr) begin
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            min_q     <= SMP_MAX;
            max_q     <= SMP_MIN;
            sample_q  <= '0;
            drop_q    <= '0;
        end else if (in_valid) begin
            acc_q     <= acc_next;
            acc_sat_q <= acc_sat_q | acc_clamp;
            if (sample < min_q) begin
                min_q <= sample;
            end
            if (sample > max_q) begin
                max_q <= sample;
            end
            sample_q <= sat_inc8(sample_q);
            if (drop) begin
                drop_q <= sat_inc8(drop_q);
            end
        end
    end

    // Blink detector: leds_prev always tracks the bus, even during clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_prev <= '0;
            blink_run <= '0;
            alarm_q   <= 1'b0;
        end else begin
            leds_prev <= leds_in;
            if (clr) begin
                blink_run <= '0;
                alarm_q   <= 1'b0;
            end else begin
                blink_run <= run_next;
                if (run_next == LIMIT_C) begin
                    alarm_q <= 1'b1;
                end
            end
        end
    end

endmodule
